// File: rtl/posit_encode_arbiter.sv
// posit_encode_arbiter: round-robin sharing of one combinational posit
// format encoder between NREQ field producers. A grant in IDLE captures the
// winner's decoded fields, ENC registers the encoded word, and EMIT holds the
// result on a valid/ready port until the downstream takes it.

// format_encoder: packs decoded posit fields (signed regime, exponent,
// mantissa, sign) into a WIDTH-bit posit. The body is built as a regime run
// followed by EN exponent bits and the mantissa, truncated to WIDTH-1 bits.
// Non-negative regimes are emitted one ulp below the boundary pattern, which
// is the reference encoder's mapping (fields 0/0/0 encode as 7'h1F).
// Negative values are the two's complement of the positive encoding.
module format_encoder #(
    parameter int WIDTH = 7,
    parameter int EN    = 1
) (
    input  logic [7:0]       regime,
    input  logic [7:0]       exponent,
    input  logic [7:0]       mantissa,
    input  logic             neg,
    output logic [WIDTH-1:0] q
);
    localparam int BW = WIDTH - 1;       // body width below the sign bit
    localparam int TW = EN + 8;          // exponent + mantissa tail width
    localparam int WW = BW + TW + 2;     // working frame width
    localparam logic [8:0] RUN_MAX = 9'(BW);

    logic [8:0]       run_s;
    logic [TW-1:0]    tail_s;
    logic [WW-1:0]    frame_s;
    logic [BW-1:0]    body_s;
    logic [WIDTH-1:0] mag_s;
    logic             unused_s;

    // Only the low EN exponent bits form the exponent field.
    assign unused_s = ^exponent;

    // Build regime run, append tail, truncate to the body, then apply sign.
    always_comb begin
        run_s   = 9'd0;
        tail_s  = {exponent[EN-1:0], mantissa};
        frame_s = {WW{1'b0}};
        body_s  = {BW{1'b0}};
        mag_s   = {WIDTH{1'b0}};
        q       = {WIDTH{1'b0}};

        // Run length: -r zeros for negative regimes, r+1 ones otherwise.
        if (regime[7]) begin
            run_s = 9'd0 - {regime[7], regime};
        end else begin
            run_s = {1'b0, regime} + 9'd1;
        end

        // A run longer than the body saturates toward minpos/maxpos.
        if (run_s > RUN_MAX) begin
            run_s = RUN_MAX;
        end else begin
            run_s = run_s;
        end

        // Zeros terminated by a one, or ones terminated by a zero.
        if (regime[7]) begin
            frame_s = {1'b1, tail_s, {(BW+1){1'b0}}} >> run_s;
        end else begin
            frame_s = ({1'b0, tail_s, {(BW+1){1'b0}}} >> run_s)
                    | ~({WW{1'b1}} >> run_s);
        end

        body_s = BW'(frame_s >> (WW - BW));

        // Negative regimes never collapse to zero; non-negative ones are
        // biased down one ulp.
        if (regime[7]) begin
            if (body_s == {BW{1'b0}}) begin
                body_s = BW'(1);
            end else begin
                body_s = body_s;
            end
        end else begin
            body_s = body_s - BW'(1);
        end

        mag_s = {1'b0, body_s};

        if (neg) begin
            q = ~mag_s + WIDTH'(1);
        end else begin
            q = mag_s;
        end
    end
endmodule

module posit_encode_arbiter #(
    parameter int WIDTH = 7,
    parameter int EN    = 1,
    parameter int NREQ  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [8*NREQ-1:0]      req_regime,
    input  logic [8*NREQ-1:0]      req_exponent,
    input  logic [8*NREQ-1:0]      req_mantissa,
    input  logic [NREQ-1:0]        req_neg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_q,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic                   busy
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic [IDW-1:0]   id_r;
    logic [7:0]       regime_r;
    logic [7:0]       exponent_r;
    logic [7:0]       mantissa_r;
    logic             neg_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_q_r;
    logic [IDW-1:0]   out_id_r;

    logic             grant_valid_s;
    logic [IDW-1:0]   grant_idx_s;
    logic [IDW+2:0]   grant_base_s;
    logic [7:0]       sel_regime_s;
    logic [7:0]       sel_exponent_s;
    logic [7:0]       sel_mantissa_s;
    logic             sel_neg_s;
    logic [WIDTH-1:0] enc_q_s;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx_v;
        grant_valid_s = 1'b0;
        grant_idx_s   = {IDW{1'b0}};
        idx_v         = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx_v = int'(rr_ptr_r) + i;
            if (idx_v >= NREQ) begin
                idx_v = idx_v - NREQ;
            end else begin
                idx_v = idx_v;
            end
            if (!grant_valid_s && req_valid[idx_v]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = IDW'(idx_v);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Pick out the granted requester's field slices.
    always_comb begin
        grant_base_s   = {grant_idx_s, 3'b000};
        sel_regime_s   = req_regime[grant_base_s +: 8];
        sel_exponent_s = req_exponent[grant_base_s +: 8];
        sel_mantissa_s = req_mantissa[grant_base_s +: 8];
        sel_neg_s      = req_neg[grant_idx_s];
    end

    // Accept strobe: one-hot to the winner, only while IDLE and out of reset.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (state_r == ST_IDLE && grant_valid_s && !rst) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    format_encoder #(
        .WIDTH (WIDTH),
        .EN    (EN)
    ) u_format_encoder (
        .regime   (regime_r),
        .exponent (exponent_r),
        .mantissa (mantissa_r),
        .neg      (neg_r),
        .q        (enc_q_s)
    );

    // Control FSM with field capture, result register and pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {IDW{1'b0}};
            id_r        <= {IDW{1'b0}};
            regime_r    <= 8'd0;
            exponent_r  <= 8'd0;
            mantissa_r  <= 8'd0;
            neg_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_q_r     <= {WIDTH{1'b0}};
            out_id_r    <= {IDW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Fields change only here, on a completed grant.
                    if (grant_valid_s) begin
                        regime_r   <= sel_regime_s;
                        exponent_r <= sel_exponent_s;
                        mantissa_r <= sel_mantissa_s;
                        neg_r      <= sel_neg_s;
                        id_r       <= grant_idx_s;
                        state_r    <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    out_q_r     <= enc_q_s;
                    out_id_r    <= id_r;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_EMIT;
                end
                ST_EMIT: begin
                    // Hold the result until taken; then advance past the winner.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (id_r == IDW'(NREQ - 1)) begin
                            rr_ptr_r <= {IDW{1'b0}};
                        end else begin
                            rr_ptr_r <= id_r + IDW'(1);
                        end
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_q     = out_q_r;
    assign out_id    = out_id_r;
    assign busy      = (state_r != ST_IDLE);
endmodule

// File: tb/tb_posit_encode_arbiter.sv
// Scoreboard bench for posit_encode_arbiter: stimulus pushes expected grants
// and results; a negedge monitor pops and compares as the DUT presents them.
module tb_posit_encode_arbiter;
    localparam int WIDTH = 7;
    localparam int EN    = 1;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [IDW-1:0]   id;
        int               gap;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [8*NREQ-1:0]    req_regime;
    logic [8*NREQ-1:0]    req_exponent;
    logic [8*NREQ-1:0]    req_mantissa;
    logic [NREQ-1:0]      req_neg;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_q;
    logic [IDW-1:0]       out_id;
    logic                 busy;
    logic                 done = 1'b0;

    exp_t                 exp_q[$];
    logic [NREQ-1:0]      grant_q[$];
    int                   compared = 0;
    int                   mismatched = 0;

    posit_encode_arbiter #(.WIDTH(WIDTH), .EN(EN), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_regime   (req_regime),
        .req_exponent (req_exponent),
        .req_mantissa (req_mantissa),
        .req_neg      (req_neg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_q        (out_q),
        .out_id       (out_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] r, input logic [7:0] e,
                           input logic [7:0] m, input logic n);
        req_regime[8*i +: 8]   = r;
        req_exponent[8*i +: 8] = e;
        req_mantissa[8*i +: 8] = m;
        req_neg[i]             = n;
    endtask

    task automatic push_res(input logic [WIDTH-1:0] q, input logic [IDW-1:0] id, input int gap);
        exp_t e;
        e.q   = q;
        e.id  = id;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: all comparisons happen here, sampled on the falling edge.
    initial begin
        logic rst_d;
        logic valid_d;
        int   cyc;
        int   last_rise;
        exp_t e;
        rst_d = 1'b0; valid_d = 1'b0; cyc = 0; last_rise = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_d) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_out_q", 32'(out_q), 32'd0);
                check("rst_out_id", 32'(out_id), 32'd0);
                check("rst_req_ready", 32'(req_ready), 32'd0);
            end
            if (rst) begin
                exp_q.delete();
                valid_d = 1'b0;
            end else begin
                check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
                if (req_ready != '0) begin
                    if (grant_q.size() == 0) begin
                        check("unexpected_grant", 32'(req_ready), 32'd0);
                    end else begin
                        check("grant", 32'(req_ready), 32'(grant_q.pop_front()));
                    end
                end
                if (out_valid) begin
                    check("ready_while_valid", 32'(req_ready), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'(out_q), 32'hFFFF);
                    end else begin
                        e = exp_q[0];
                        check("out_q", 32'(out_q), 32'(e.q));
                        check("out_id", 32'(out_id), 32'(e.id));
                        if (!valid_d) begin
                            if (e.gap != 0) check("result_gap", 32'(cyc - last_rise), 32'(e.gap));
                            last_rise = cyc;
                        end
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                valid_d = out_valid;
            end
            rst_d = rst;
            if (done || cyc > 3000) begin
                if (!done) check("watchdog", 32'(cyc), 32'd0);
                check("results_drained", 32'(exp_q.size()), 32'd0);
                check("grants_drained", 32'(grant_q.size()), 32'd0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
                $finish;
            end
        end
    end

    // Stimulus: directed vectors with hand-computed encodings.
    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        out_ready    = 1'b1;
        req_regime   = 32'hA5C3_7E19;
        req_exponent = 32'h3C5A_9617;
        req_mantissa = 32'hF00D_BEEF;
        req_neg      = 4'b1010;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single request, 1.0-ish fields on requester 2.
        set_req(2, 8'h00, 8'h00, 8'h00, 1'b0);
        grant_q.push_back(4'b0100);
        push_res(7'h1F, 2'd2, 0);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Same fields, negative sign.
        set_req(2, 8'h00, 8'h00, 8'h00, 1'b1);
        grant_q.push_back(4'b0100);
        push_res(7'h61, 2'd2, 0);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Negative regime on requester 1.
        set_req(1, 8'hFF, 8'h00, 8'h00, 1'b0);
        grant_q.push_back(4'b0010);
        push_res(7'h10, 2'd1, 0);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Regime -2, exponent 1, fraction .5 on requester 0 (pointer wraps).
        set_req(0, 8'hFE, 8'h01, 8'h80, 1'b0);
        grant_q.push_back(4'b0001);
        push_res(7'h0E, 2'd0, 0);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Reset while stalled in EMIT: result discarded, pointer cleared.
        set_req(3, 8'h00, 8'h00, 8'h00, 1'b0);
        grant_q.push_back(4'b1000);
        push_res(7'h1F, 2'd3, 0);
        out_ready = 1'b0;
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Round-robin with all four requesting.
        set_req(0, 8'h00, 8'h00, 8'h00, 1'b0);
        set_req(1, 8'hFF, 8'h00, 8'h00, 1'b0);
        set_req(2, 8'h00, 8'h00, 8'h00, 1'b1);
        set_req(3, 8'hFE, 8'h01, 8'h80, 1'b0);
        grant_q.push_back(4'b0001); grant_q.push_back(4'b0010);
        grant_q.push_back(4'b0100); grant_q.push_back(4'b1000);
        grant_q.push_back(4'b0001);
        push_res(7'h1F, 2'd0, 0);
        push_res(7'h10, 2'd1, 3);
        push_res(7'h61, 2'd2, 3);
        push_res(7'h0E, 2'd3, 3);
        push_res(7'h1F, 2'd0, 3);
        req_valid = 4'b1111;
        repeat (13) tick();
        req_valid = '0;
        repeat (3) tick();

        // Backpressure: 5 stalled EMIT cycles, then next grant to id+1.
        grant_q.push_back(4'b0010);
        grant_q.push_back(4'b0100);
        push_res(7'h10, 2'd1, 0);
        push_res(7'h61, 2'd2, 0);
        out_ready = 1'b0;
        req_valid = 4'b0110;
        tick();
        repeat (5) tick();
        out_ready = 1'b1;
        tick();
        tick();
        req_valid = '0;
        repeat (4) tick();

        done = 1'b1;
        repeat (5) tick();
    end
endmodule
